// File: rtl/object_table_scheduler_pkg.sv
// Shared widths, slot field layout, op codes and FSM encoding for the object table scheduler.
package object_table_scheduler_pkg;

  localparam int unsigned SLOTS      = 8;
  localparam int unsigned TYPE_W     = 3;
  localparam int unsigned X_W        = 10;
  localparam int unsigned Y_W        = 9;
  localparam int unsigned W_W        = 10;
  localparam int unsigned H_W        = 9;
  localparam int unsigned FIFO_DEPTH = 4;

  localparam int unsigned DATA_W = TYPE_W + X_W + Y_W + W_W + H_W;
  localparam int unsigned SLOT_W = $clog2(SLOTS);
  localparam int unsigned CNT_W  = SLOT_W + 1;

  // Slot field layout, LSB first: type, x, y, width, height.
  localparam int unsigned TYPE_LSB = 0;
  localparam int unsigned X_LSB    = TYPE_LSB + TYPE_W;
  localparam int unsigned Y_LSB    = X_LSB + X_W;
  localparam int unsigned W_LSB    = Y_LSB + Y_W;
  localparam int unsigned H_LSB    = W_LSB + W_W;

  localparam int unsigned CMD_W = 2 + SLOT_W + DATA_W;

  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(SLOTS);

  typedef enum logic [1:0] {
    OP_RSVD    = 2'b00,
    OP_SPAWN   = 2'b01,
    OP_MOVE    = 2'b10,
    OP_DESPAWN = 2'b11
  } op_e;

  typedef enum logic [1:0] {StIdle, StExec, StShift, StCommit} state_e;

  typedef struct packed {
    logic [1:0]        op;
    logic [SLOT_W-1:0] slot;
    logic [DATA_W-1:0] data;
  } cmd_t;

  typedef logic [SLOTS-1:0][DATA_W-1:0] table_t;

  function automatic logic [TYPE_W-1:0] obj_type(logic [DATA_W-1:0] d);
    return d[TYPE_LSB +: TYPE_W];
  endfunction

endpackage

// File: rtl/object_table_scheduler_if.sv
// Command/response port between game-logic requesters and the object table scheduler.
interface object_table_scheduler_if;
  import object_table_scheduler_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [SLOT_W-1:0] cmd_slot;
  logic [TYPE_W-1:0] cmd_type;
  logic [X_W-1:0]    cmd_x;
  logic [Y_W-1:0]    cmd_y;
  logic [W_W-1:0]    cmd_w;
  logic [H_W-1:0]    cmd_h;
  logic              rsp_valid;
  logic              rsp_err;
  logic [SLOT_W-1:0] rsp_slot;

  modport master (
    output cmd_valid, cmd_op, cmd_slot, cmd_type, cmd_x, cmd_y, cmd_w, cmd_h,
    input  cmd_ready, rsp_valid, rsp_err, rsp_slot
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_slot, cmd_type, cmd_x, cmd_y, cmd_w, cmd_h,
    output cmd_ready, rsp_valid, rsp_err, rsp_slot
  );

endinterface

// File: rtl/object_table_scheduler_cmd_fifo.sv
// Synchronous command FIFO; pointers carry an extra wrap bit to tell full from empty.
module object_table_scheduler_cmd_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam logic [PtrW:0] PtrOne = 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW:0]    wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[PtrW] != rptr_q[PtrW]) && (wptr_q[PtrW-1:0] == rptr_q[PtrW-1:0]);
  assign rdata   = mem_q[rptr_q[PtrW-1:0]];
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PtrOne;
      if (do_pop)  rptr_q <= rptr_q + PtrOne;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wptr_q[PtrW-1:0]] <= wdata;
  end

endmodule

// File: rtl/object_table_scheduler.sv
// Applies buffered SPAWN/MOVE/DESPAWN commands to a compacted shadow table and copies it
// to the display-facing table only on vertical blank.
module object_table_scheduler
  import object_table_scheduler_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    vblank,
  object_table_scheduler_if.slave cmd,
  output logic [CNT_W-1:0]        obj_count,
  output logic [SLOTS*DATA_W-1:0] gamedata,
  output logic                    commit_done
);

  state_e            state_q, state_d;
  table_t            shadow_q, shadow_d, gamedata_q, gamedata_d;
  cmd_t              exec_q, exec_d, fifo_wdata, fifo_rdata;
  logic [SLOT_W-1:0] idx_q, idx_d, idx_inc;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              pending_q, pending_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [SLOT_W-1:0] rsp_slot_q, rsp_slot_d;
  logic              commit_done_q, commit_done_d;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic              slot_live, slot_last;

  assign cmd.cmd_ready = reset && !fifo_full;
  assign fifo_push     = cmd.cmd_valid && cmd.cmd_ready;
  assign fifo_wdata    = '{op:   cmd.cmd_op,
                           slot: cmd.cmd_slot,
                           data: {cmd.cmd_h, cmd.cmd_w, cmd.cmd_y, cmd.cmd_x, cmd.cmd_type}};

  object_table_scheduler_cmd_fifo #(
    .Width(CMD_W),
    .Depth(FIFO_DEPTH)
  ) u_cmd_fifo (
    .clock(clock),
    .reset(reset),
    .push (fifo_push),
    .wdata(fifo_wdata),
    .pop  (fifo_pop),
    .rdata(fifo_rdata),
    .full (fifo_full),
    .empty(fifo_empty)
  );

  assign idx_inc   = idx_q + 1'b1;
  assign slot_live = {1'b0, exec_q.slot} < count_q;
  assign slot_last = {1'b0, exec_q.slot} == (count_q - 1'b1);

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    exec_d        = exec_q;
    shadow_d      = shadow_q;
    gamedata_d    = gamedata_q;
    count_d       = count_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = rsp_err_q;
    rsp_slot_d    = rsp_slot_q;
    commit_done_d = 1'b0;
    fifo_pop      = 1'b0;
    // A vblank seen while a commit is pending merges into it.
    pending_d     = vblank || (pending_q && (state_q != StCommit));

    unique case (state_q)
      StIdle: begin
        if (pending_q) begin
          state_d = StCommit;
        end else if (!fifo_empty) begin
          fifo_pop = 1'b1;
          exec_d   = fifo_rdata;
          state_d  = StExec;
        end
      end

      StExec: begin
        state_d     = StIdle;
        rsp_valid_d = 1'b1;
        rsp_err_d   = 1'b1;
        rsp_slot_d  = exec_q.slot;
        case (exec_q.op)
          OP_SPAWN: begin
            rsp_slot_d = count_q[SLOT_W-1:0];
            if (count_q != FULL_COUNT && obj_type(exec_q.data) != '0) begin
              shadow_d[count_q[SLOT_W-1:0]] = exec_q.data;
              count_d   = count_q + 1'b1;
              rsp_err_d = 1'b0;
            end
          end
          OP_MOVE: begin
            if (slot_live) begin
              shadow_d[exec_q.slot][X_LSB +: X_W] = exec_q.data[X_LSB +: X_W];
              shadow_d[exec_q.slot][Y_LSB +: Y_W] = exec_q.data[Y_LSB +: Y_W];
              rsp_err_d = 1'b0;
            end
          end
          OP_DESPAWN: begin
            if (slot_live) begin
              rsp_err_d = 1'b0;
              // The last live slot needs no compaction, so it retires here directly.
              if (slot_last) begin
                shadow_d[exec_q.slot] = '0;
                count_d = count_q - 1'b1;
              end else begin
                rsp_valid_d = 1'b0;
                rsp_err_d   = rsp_err_q;
                rsp_slot_d  = rsp_slot_q;
                idx_d       = exec_q.slot;
                state_d     = StShift;
              end
            end
          end
          default: ;
        endcase
      end

      StShift: begin
        shadow_d[idx_q] = shadow_q[idx_inc];
        idx_d = idx_inc;
        // Last move also clears the vacated tail slot.
        if (({1'b0, idx_q} + 2'd2) == count_q) begin
          shadow_d[idx_inc] = '0;
          count_d     = count_q - 1'b1;
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_slot_d  = exec_q.slot;
          state_d     = StIdle;
        end
      end

      StCommit: begin
        gamedata_d    = shadow_q;
        commit_done_d = 1'b1;
        state_d       = StIdle;
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= StIdle;
      idx_q         <= '0;
      exec_q        <= '0;
      shadow_q      <= '0;
      gamedata_q    <= '0;
      count_q       <= '0;
      pending_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_slot_q    <= '0;
      commit_done_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      exec_q        <= exec_d;
      shadow_q      <= shadow_d;
      gamedata_q    <= gamedata_d;
      count_q       <= count_d;
      pending_q     <= pending_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_slot_q    <= rsp_slot_d;
      commit_done_q <= commit_done_d;
    end
  end

  assign cmd.rsp_valid = rsp_valid_q;
  assign cmd.rsp_err   = rsp_err_q;
  assign cmd.rsp_slot  = rsp_slot_q;
  assign obj_count     = count_q;
  assign gamedata      = gamedata_q;
  assign commit_done   = commit_done_q;

endmodule

// File: tb/tb_object_table_scheduler.sv
// Scoreboard bench: directed commands push expected responses; a negedge monitor checks them.
module tb_object_table_scheduler;
  import object_table_scheduler_pkg::*;

  logic                    clock = 1'b0;
  logic                    reset = 1'b0;
  logic                    vblank = 1'b0;
  logic [CNT_W-1:0]        obj_count;
  logic [SLOTS*DATA_W-1:0] gamedata;
  logic                    commit_done;

  object_table_scheduler_if bus ();

  object_table_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .vblank     (vblank),
    .cmd        (bus),
    .obj_count  (obj_count),
    .gamedata   (gamedata),
    .commit_done(commit_done)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit err;
    int slot;  // negative: slot not checked
    int cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  bit   saw_stall;

  function automatic logic [DATA_W-1:0] mk_obj(int t, int x, int y, int w, int h);
    logic [DATA_W-1:0] d;
    d = '0;
    d[TYPE_LSB +: TYPE_W] = TYPE_W'(t);
    d[X_LSB +: X_W]       = X_W'(x);
    d[Y_LSB +: Y_W]       = Y_W'(y);
    d[W_LSB +: W_W]       = W_W'(w);
    d[H_LSB +: H_W]       = H_W'(h);
    return d;
  endfunction

  function automatic logic [DATA_W-1:0] obj(int i);
    return mk_obj(i % 7 + 1, 20 * i + 5, 10 * i + 7, 8 + i, 16 + i);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic check_slot(input string name, input int i, input logic [DATA_W-1:0] req);
    check(name, 64'(gamedata[i*DATA_W +: DATA_W]), 64'(req));
  endtask

  // Response monitor.
  always @(negedge clock) begin
    exp_t e;
    if (bus.rsp_valid) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got err=%0d slot=%0d, required no response",
                 bus.rsp_err, bus.rsp_slot);
      end else begin
        e = exp_q.pop_front();
        if (bus.rsp_err !== e.err || obj_count !== CNT_W'(e.cnt) ||
            (e.slot >= 0 && bus.rsp_slot !== SLOT_W'(e.slot))) begin
          n_fail++;
          $display("FAIL rsp: got err=%0d slot=%0d count=%0d, required err=%0d slot=%0d count=%0d",
                   bus.rsp_err, bus.rsp_slot, obj_count, e.err, e.slot, e.cnt);
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after acceptance with cmd_valid still high.
  task automatic send(input logic [1:0] op, input int slot, input logic [DATA_W-1:0] d,
                      input bit e_err, input int e_slot, input int e_cnt);
    int   t;
    exp_t e;
    t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_slot  = SLOT_W'(slot);
    bus.cmd_type  = d[TYPE_LSB +: TYPE_W];
    bus.cmd_x     = d[X_LSB +: X_W];
    bus.cmd_y     = d[Y_LSB +: Y_W];
    bus.cmd_w     = d[W_LSB +: W_W];
    bus.cmd_h     = d[H_LSB +: H_W];
    while (!bus.cmd_ready && t < 100) begin
      saw_stall = 1'b1;
      @(negedge clock);
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL accept_timeout: got cmd_ready=0 for 100 cycles, required 1");
      bus.cmd_valid = 1'b0;
      return;
    end
    e.err = e_err;
    e.slot = e_slot;
    e.cnt = e_cnt;
    exp_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle_n(input int n);
    bus.cmd_valid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.cmd_valid = 1'b0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clock);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic latency(input string name, input int req);
    int lat;
    bus.cmd_valid = 1'b0;
    lat = 1;
    while (!bus.rsp_valid && lat < 50) begin
      @(negedge clock);
      lat++;
    end
    check(name, 64'(lat), 64'(req));
  endtask

  task automatic commit(input string name);
    int cd;
    cd = 0;
    bus.cmd_valid = 1'b0;
    vblank = 1'b1;
    @(negedge clock);
    vblank = 1'b0;
    repeat (20) begin
      @(negedge clock);
      if (commit_done) cd++;
    end
    check(name, 64'(cd), 64'd1);
  endtask

  task automatic do_reset();
    bus.cmd_valid = 1'b0;
    vblank = 1'b0;
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("ready_in_reset", 64'(bus.cmd_ready), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  initial begin
    bus.cmd_valid = 1'b0;
    bus.cmd_op = '0;
    bus.cmd_slot = '0;
    bus.cmd_type = '0;
    bus.cmd_x = '0;
    bus.cmd_y = '0;
    bus.cmd_w = '0;
    bus.cmd_h = '0;
    @(negedge clock);

    // Reset state and a single SPAWN that only reaches gamedata after vblank.
    do_reset();
    check("ready_after_reset", 64'(bus.cmd_ready), 64'd1);
    check("count_reset", 64'(obj_count), 64'd0);
    check("gd_reset", 64'(|gamedata), 64'd0);
    check("rsp_valid_reset", 64'(bus.rsp_valid), 64'd0);
    check("commit_done_reset", 64'(commit_done), 64'd0);
    send(OP_SPAWN, 0, mk_obj(1, 50, 300, 40, 40), 1'b0, 0, 1);
    latency("lat_spawn", 3);
    drain();
    check("gd_before_commit", 64'(|gamedata), 64'd0);
    commit("commit_done_t1");
    check_slot("t1_slot0", 0, mk_obj(1, 50, 300, 40, 40));
    check_slot("t1_slot1", 1, '0);

    // Fill all slots, then overflow.
    do_reset();
    for (int i = 0; i < 8; i++) send(OP_SPAWN, 0, obj(i), 1'b0, i, i + 1);
    send(OP_SPAWN, 0, obj(0), 1'b1, -1, 8);
    drain();
    check("count_full", 64'(obj_count), 64'd8);
    commit("commit_done_t2");
    check_slot("t2_slot0", 0, obj(0));
    check_slot("t2_slot7", 7, obj(7));

    // DESPAWN compaction.
    do_reset();
    for (int i = 0; i < 5; i++) send(OP_SPAWN, 0, obj(i), 1'b0, i, i + 1);
    drain();
    send(OP_DESPAWN, 1, '0, 1'b0, 1, 4);
    latency("lat_despawn", 6);
    drain();
    commit("commit_done_t3");
    check_slot("t3_slot0", 0, obj(0));
    check_slot("t3_slot1", 1, obj(2));
    check_slot("t3_slot2", 2, obj(3));
    check_slot("t3_slot3", 3, obj(4));
    check_slot("t3_slot4", 4, '0);
    send(OP_DESPAWN, 3, '0, 1'b0, 3, 3);
    latency("lat_despawn_last", 3);
    drain();

    // MOVE and error cases on a 3-object table.
    send(OP_MOVE, 7, mk_obj(0, 1, 1, 0, 0), 1'b1, 7, 3);
    send(OP_MOVE, 2, mk_obj(0, 600, 10, 0, 0), 1'b0, 2, 3);
    send(OP_SPAWN, 0, mk_obj(0, 5, 5, 5, 5), 1'b1, -1, 3);
    send(2'b00, 5, '0, 1'b1, -1, 3);
    send(OP_DESPAWN, 3, '0, 1'b1, 3, 3);
    drain();
    commit("commit_done_t4");
    check_slot("t4_slot0", 0, obj(0));
    check_slot("t4_slot1", 1, obj(2));
    check_slot("t4_slot2_moved", 2, mk_obj(4, 600, 10, 11, 19));
    check_slot("t4_slot3", 3, '0);

    // Back-to-back commands behind a long compaction fill the FIFO.
    do_reset();
    for (int i = 0; i < 7; i++) send(OP_SPAWN, 0, obj(i), 1'b0, i, i + 1);
    drain();
    saw_stall = 1'b0;
    send(OP_DESPAWN, 0, '0, 1'b0, 0, 6);
    send(OP_SPAWN, 0, mk_obj(6, 100, 200, 30, 20), 1'b0, 6, 7);
    send(OP_SPAWN, 0, mk_obj(7, 300, 150, 50, 60), 1'b0, 7, 8);
    send(OP_SPAWN, 0, mk_obj(2, 1, 1, 1, 1), 1'b1, -1, 8);
    send(OP_SPAWN, 0, mk_obj(0, 9, 9, 9, 9), 1'b1, -1, 8);
    send(OP_MOVE, 1, mk_obj(0, 600, 10, 0, 0), 1'b0, 1, 8);
    check("ready_dropped", 64'(saw_stall), 64'd1);
    drain();
    commit("commit_done_t5");
    check_slot("t5_slot0", 0, obj(1));
    check_slot("t5_slot1", 1, mk_obj(3, 600, 10, 10, 18));
    check_slot("t5_slot5", 5, obj(6));
    check_slot("t5_slot6", 6, mk_obj(6, 100, 200, 30, 20));
    check_slot("t5_slot7", 7, mk_obj(7, 300, 150, 50, 60));

    // vblank during SHIFT waits for compaction; reset mid-SHIFT aborts.
    do_reset();
    for (int i = 0; i < 6; i++) send(OP_SPAWN, 0, obj(i), 1'b0, i, i + 1);
    drain();
    commit("commit_done_t6a");
    send(OP_DESPAWN, 0, '0, 1'b0, 0, 5);
    idle_n(2);
    vblank = 1'b1;
    @(negedge clock);
    vblank = 1'b0;
    check_slot("t6_gd_stable", 0, obj(0));
    begin
      int cd;
      cd = 0;
      repeat (20) begin
        @(negedge clock);
        if (commit_done) cd++;
      end
      check("commit_done_t6b", 64'(cd), 64'd1);
    end
    check("t6_rsp_outstanding", 64'(exp_q.size()), 64'd0);
    for (int i = 0; i < 5; i++) check_slot("t6_compacted", i, obj(i + 1));
    check_slot("t6_slot5", 5, '0);
    send(OP_DESPAWN, 0, '0, 1'b0, 0, 4);
    idle_n(3);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clock);
    check("rst_count", 64'(obj_count), 64'd0);
    check("rst_gd", 64'(|gamedata), 64'd0);
    check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    check("rst_commit_done", 64'(commit_done), 64'd0);
    check("rst_ready", 64'(bus.cmd_ready), 64'd0);
    reset = 1'b1;
    @(negedge clock);
    check("rst_ready_after", 64'(bus.cmd_ready), 64'd1);
    idle_n(10);
    commit("commit_done_t6c");
    check("rst_gd_after_commit", 64'(|gamedata), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
